// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the serial "101" pattern transmitter and the matching
// sequence detector.
//   seq_state_e : FSM state encoding (IDLE, SHIFT, GAP, DONE)
//   PAT_101     : default pattern loaded into the transmitter at reset
// -----------------------------------------------------------------------------
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        GAP   = 2'b10,
        DONE  = 2'b11
    } seq_state_e;

    localparam logic [2:0] PAT_101 = 3'b101;

endpackage

// File: rtl/seq_tx_counter.sv
// -----------------------------------------------------------------------------
// seq_tx_counter
// Bit-index down-counter (PAT_W-1 .. 0) and repeat down-counter (N .. 1) for
// the serial pattern transmitter.
// Ports:
//   i_clk       : rising-edge clock
//   i_rst_n     : synchronous active-low reset (clears both counters)
//   i_load      : accepted start with a non-zero repeat count
//   i_repeat    : repeat count to latch on i_load
//   i_step      : one pattern bit was just emitted
//   o_next_idx  : index of the bit to emit after the current one
//   o_last_bit  : current bit is the LSB of the pattern
//   o_last_rep  : current repetition is the final one
// -----------------------------------------------------------------------------
module seq_tx_counter #(
    parameter int PAT_W    = 3,
    parameter int REPEAT_W = 4,
    localparam int IDX_W   = (PAT_W > 1) ? $clog2(PAT_W) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_load,
    input  logic [REPEAT_W-1:0] i_repeat,
    input  logic                i_step,
    output logic [IDX_W-1:0]    o_next_idx,
    output logic                o_last_bit,
    output logic                o_last_rep
);

    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(PAT_W - 1);

    logic [IDX_W-1:0]    r_bit_idx;
    logic [REPEAT_W-1:0] r_rep;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_bit_idx <= '0;
            r_rep     <= '0;
        end else if (i_load) begin
            r_bit_idx <= TOP_IDX;
            r_rep     <= i_repeat;
        end else if (i_step) begin
            if (o_last_bit) begin
                r_bit_idx <= TOP_IDX;
                // Stop at 1 so the final repetition stays flagged as last.
                if (!o_last_rep) begin
                    r_rep <= r_rep - 1'b1;
                end
            end else begin
                r_bit_idx <= r_bit_idx - 1'b1;
            end
        end
    end

    assign o_last_bit = (r_bit_idx == '0);
    assign o_last_rep = (r_rep == REPEAT_W'(1));
    assign o_next_idx = o_last_bit ? TOP_IDX : (r_bit_idx - 1'b1);

endmodule

// File: rtl/seq_gen_101_tx.sv
// -----------------------------------------------------------------------------
// seq_gen_101_tx
// Serial pattern transmitter: shifts a PAT_W-bit pattern out MSB-first,
// repeat_cnt times, using a start/busy/done handshake.
//
// Handshake: start is sampled only in IDLE. When it is accepted the first
// pattern bit is on d_out (d_valid=1) right after that edge, one bit per
// cycle follows, and done pulses for one cycle (busy still 1) after the last
// bit. busy drops in the following IDLE cycle. start/load_pat seen while busy
// are dropped, never queued.
//
// Ports:
//   clock      : rising-edge clock
//   reset      : synchronous active-low reset
//   start      : transmission request (IDLE only)
//   load_pat   : load pattern_in into the pattern register (IDLE only)
//   pattern_in : new pattern
//   repeat_cnt : repetitions, latched on accepted start (0 = done only)
//   d_out      : serial data, 0 whenever d_valid=0
//   d_valid    : d_out carries a pattern bit
//   busy       : state != IDLE
//   done       : one-cycle end-of-transmission pulse
//   dbg_state  : current FSM state (seq_state_e encoding)
//
// Build option: define SEQ_GEN_GAP_EN to insert one idle GAP cycle between
// consecutive repetitions.
// -----------------------------------------------------------------------------
module seq_gen_101_tx
    import seq_pkg::*;
#(
    parameter int               PAT_W    = 3,
    parameter logic [PAT_W-1:0] PATTERN  = PAT_W'(PAT_101),
    parameter int               REPEAT_W = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                load_pat,
    input  logic [PAT_W-1:0]    pattern_in,
    input  logic [REPEAT_W-1:0] repeat_cnt,
    output logic                d_out,
    output logic                d_valid,
    output logic                busy,
    output logic                done,
    output logic [1:0]          dbg_state
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    seq_state_e       r_state;
    logic [PAT_W-1:0] r_pat;
    logic             r_d_out;
    logic             r_d_valid;
    logic             r_busy;
    logic             r_done;

    logic [PAT_W-1:0] w_pat_src;
    logic             w_load;
    logic             w_step;
    logic [IDX_W-1:0] w_next_idx;
    logic             w_last_bit;
    logic             w_last_rep;

    // A simultaneous load_pat + start transmits the incoming pattern.
    assign w_pat_src = load_pat ? pattern_in : r_pat;
    assign w_load    = (r_state == IDLE) && start && (repeat_cnt != '0);
    assign w_step    = (r_state == SHIFT);

    seq_tx_counter #(
        .PAT_W    (PAT_W),
        .REPEAT_W (REPEAT_W)
    ) u_counter (
        .i_clk      (clock),
        .i_rst_n    (reset),
        .i_load     (w_load),
        .i_repeat   (repeat_cnt),
        .i_step     (w_step),
        .o_next_idx (w_next_idx),
        .o_last_bit (w_last_bit),
        .o_last_rep (w_last_rep)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_pat     <= PATTERN;
            r_d_out   <= 1'b0;
            r_d_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            // Data and pulse outputs default low; each state re-asserts them.
            r_d_out   <= 1'b0;
            r_d_valid <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_busy <= 1'b0;
                    if (load_pat) begin
                        r_pat <= pattern_in;
                    end
                    if (start) begin
                        r_busy <= 1'b1;
                        if (repeat_cnt != '0) begin
                            r_state   <= SHIFT;
                            r_d_out   <= w_pat_src[PAT_W-1];
                            r_d_valid <= 1'b1;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (w_last_bit && w_last_rep) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
`ifdef SEQ_GEN_GAP_EN
                    else if (w_last_bit) begin
                        r_state <= GAP;
                    end
`endif
                    else begin
                        // w_next_idx wraps to the MSB after the LSB, giving
                        // back-to-back repetitions.
                        r_d_out   <= r_pat[w_next_idx];
                        r_d_valid <= 1'b1;
                    end
                end
`ifdef SEQ_GEN_GAP_EN
                GAP: begin
                    r_state   <= SHIFT;
                    r_d_out   <= r_pat[PAT_W-1];
                    r_d_valid <= 1'b1;
                end
`endif
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign d_out     = r_d_out;
    assign d_valid   = r_d_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_gen_101_tx.sv
// -----------------------------------------------------------------------------
// tb_seq_gen_101_tx
// Self-checking bench for seq_gen_101_tx. A transaction-level model expands
// each accepted request into the per-cycle output stream it must produce
// (pattern bits MSB-first, optional gap cycles, done, trailing idle) and the
// bench compares the DUT against that stream cycle by cycle.
// Honours SEQ_GEN_GAP_EN when the same macro is defined for the build.
// -----------------------------------------------------------------------------
module tb_seq_gen_101_tx;

    localparam int PAT_W    = 3;
    localparam int REPEAT_W = 4;
`ifdef SEQ_GEN_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic                start = 1'b0;
    logic                load_pat = 1'b0;
    logic [PAT_W-1:0]    pattern_in = '0;
    logic [REPEAT_W-1:0] repeat_cnt = '0;
    logic                d_out;
    logic                d_valid;
    logic                busy;
    logic                done;
    logic [1:0]          dbg_state;

    always #5 clock = ~clock;

    seq_gen_101_tx #(
        .PAT_W    (PAT_W),
        .PATTERN  (3'b101),
        .REPEAT_W (REPEAT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .load_pat   (load_pat),
        .pattern_in (pattern_in),
        .repeat_cnt (repeat_cnt),
        .d_out      (d_out),
        .d_valid    (d_valid),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard ----------------
    // Entry layout: {state[1:0], busy, done, d_valid, d_out}
    logic [5:0]       exp_q[$];
    logic [PAT_W-1:0] m_pat;
    int               n_checks = 0;
    int               n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [5:0] e);
        check({tag, ".state"},   32'(dbg_state), 32'(e[5:4]));
        check({tag, ".busy"},    32'(busy),      32'(e[3]));
        check({tag, ".done"},    32'(done),      32'(e[2]));
        check({tag, ".d_valid"}, 32'(d_valid),   32'(e[1]));
        check({tag, ".d_out"},   32'(d_out),     32'(e[0]));
    endtask

    // Reference model: one request -> the full expected output stream.
    task automatic push_tx(input logic [PAT_W-1:0] pat, input int n);
        for (int r = 0; r < n; r++) begin
            for (int b = PAT_W - 1; b >= 0; b--) begin
                exp_q.push_back({2'b01, 1'b1, 1'b0, 1'b1, pat[b]});
            end
            if (GAP_EN && (r < n - 1)) begin
                exp_q.push_back({2'b10, 1'b1, 1'b0, 1'b0, 1'b0});
            end
        end
        exp_q.push_back({2'b11, 1'b1, 1'b1, 1'b0, 1'b0});
        exp_q.push_back({2'b00, 1'b0, 1'b0, 1'b0, 1'b0});
    endtask

    // ---------------- driver tasks ----------------
    // Compares one queued entry per cycle. For the first `hold` entries the
    // current inputs are left untouched; afterwards, while the DUT is busy,
    // optional noise on start/load_pat exercises the "ignored while busy" rule.
    task automatic drain(input string tag, input bit noise, input int hold);
        int k = 0;
        logic [5:0] e;
        while (exp_q.size() > 0) begin
            @(negedge clock);
            e = exp_q.pop_front();
            check_outputs(tag, e);
            k++;
            if (k <= hold) begin
                // keep current inputs
            end else if (noise && e[3]) begin
                start      = 1'($urandom_range(0, 1));
                load_pat   = 1'($urandom_range(0, 1));
                pattern_in = PAT_W'($urandom_range(0, 7));
                repeat_cnt = REPEAT_W'($urandom_range(0, 15));
            end else begin
                start    = 1'b0;
                load_pat = 1'b0;
            end
        end
        start    = 1'b0;
        load_pat = 1'b0;
    endtask

    task automatic run_tx(input string tag, input bit do_load, input logic [PAT_W-1:0] pat,
                          input int n, input bit noise);
        @(negedge clock);
        start      = 1'b1;
        load_pat   = do_load;
        pattern_in = pat;
        repeat_cnt = REPEAT_W'(n);
        if (do_load) m_pat = pat;
        push_tx(m_pat, n);
        drain(tag, noise, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        m_pat = 3'b101;

        // Reset held for two cycles, then idle outputs for five cycles.
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_outputs("reset_idle", 6'b00_0000);
            @(negedge clock);
        end

        // Default pattern, single repetition.
        run_tx("rep1", 1'b0, '0, 1, 1'b0);
        // Two repetitions back-to-back (or separated by a gap).
        run_tx("rep2", 1'b0, '0, 2, 1'b0);
        // Load and start together: the new pattern is transmitted.
        run_tx("load_start", 1'b1, 3'b110, 1, 1'b0);

        // load_pat while busy must be ignored.
        @(negedge clock);
        start      = 1'b1;
        repeat_cnt = 4'd1;
        push_tx(m_pat, 1);
        @(negedge clock);
        check_outputs("busy_load", exp_q.pop_front());
        start      = 1'b0;
        load_pat   = 1'b1;
        pattern_in = 3'b011;
        drain("busy_load", 1'b0, 0);
        run_tx("after_busy_load", 1'b0, '0, 1, 1'b0);

        // repeat_cnt == 0: done one cycle after start, no data.
        run_tx("rep0", 1'b0, '0, 0, 1'b0);
        // Maximum repeat count is sent in full.
        run_tx("rep_max", 1'b0, '0, 15, 1'b0);

        // start held high: re-accepted in the IDLE cycle after done.
        @(negedge clock);
        start      = 1'b1;
        repeat_cnt = 4'd1;
        push_tx(m_pat, 1);
        push_tx(m_pat, 1);
        drain("start_held", 1'b0, PAT_W + 2);

        // Mid-transmission reset: abort with no done, pattern back to 101.
        @(negedge clock);
        start      = 1'b1;
        load_pat   = 1'b1;
        pattern_in = 3'b110;
        repeat_cnt = 4'd3;
        @(negedge clock);
        start    = 1'b0;
        load_pat = 1'b0;
        check_outputs("abort_b0", {2'b01, 1'b1, 1'b0, 1'b1, 1'b1});
        @(negedge clock);
        check_outputs("abort_b1", {2'b01, 1'b1, 1'b0, 1'b1, 1'b1});
        reset = 1'b0;
        @(negedge clock);
        check_outputs("abort_rst", 6'b00_0000);
        reset = 1'b1;
        @(negedge clock);
        check_outputs("abort_after", 6'b00_0000);
        m_pat = 3'b101;
        run_tx("abort_default_pat", 1'b0, '0, 1, 1'b0);

        // Randomized requests with noise on the inputs while busy.
        for (int t = 0; t < 30; t++) begin
            run_tx("random", 1'($urandom_range(0, 1)), PAT_W'($urandom_range(0, 7)),
                   int'($urandom_range(0, 6)), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_gen_101_tx.md
Name: seq_gen_101_tx

Overview:
- Serial pattern transmitter: the driving end of the serial-sequence-detector interface.
- Shifts a programmable PAT_W-bit pattern out MSB-first on a 1-bit line, repeated a requested number of times.
- Uses a start/busy/done handshake.
- Feeds d_in of the 101 sequence detector in self-checking benches and in on-chip loopback.

Parameters:
- PAT_W, 3: pattern width in bits (>=2).
- PATTERN, 3'b101: pattern loaded at reset.
- REPEAT_W, 4: width of the repeat-count input.

Ports:
- clock  input  1  single rising-edge clock.
- reset  input  1  synchronous, active-low reset, sampled on rising clock.
- start  input  1  request transmission; sampled only in IDLE.
- load_pat  input  1  load pattern_in into the pattern register; sampled only in IDLE.
- pattern_in  input  PAT_W  new pattern value.
- repeat_cnt  input  REPEAT_W  number of pattern repetitions; latched on accepted start.
- d_out  output  1  serial data, registered.
- d_valid  output  1  high while d_out carries a pattern bit.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse at end of transmission.

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=IDLE; d_out=0, d_valid=0, busy=0, done=0.
  - Pattern register=PATTERN; bit and repeat counters=0.
  - A mid-transmission reset aborts immediately; no done pulse.
- States:
  - IDLE: start==1 -> SHIFT if repeat_cnt!=0, else DONE.
  - SHIFT: last bit of last repetition sent -> DONE. With SEQ_GEN_GAP_EN, last bit of a non-last repetition -> GAP.
  - GAP (optional): -> SHIFT.
  - DONE: -> IDLE.
- Accepting start at edge k:
  - Bit PAT_W-1 appears on d_out, d_valid=1, from edge k+1.
  - One bit per cycle, MSB first; the next repetition follows the LSB back-to-back.
  - Total d_valid cycles = PAT_W*repeat_cnt.
- DONE lasts one cycle: done=1, d_valid=0, d_out=0, busy=1. The next cycle returns to IDLE with busy=0.
- repeat_cnt==0: no d_valid cycles; done pulses at edge k+1.
- d_out=0 whenever d_valid=0.
- load_pat in IDLE: pattern register<=pattern_in at that edge.
- load_pat and start both high in IDLE: the new pattern_in is transmitted.
- load_pat or start while busy: ignored (no queuing).
- start held high continuously: a new transmission is accepted in the first IDLE cycle after done.
- Counters:
  - Bit index counts PAT_W-1 down to 0.
  - Repeat counter counts latched value down to 1.
  - No wrap beyond 2^REPEAT_W-1; the maximum value is transmitted exactly.

Optional Feature:
- Macro SEQ_GEN_GAP_EN.
- Defined: one GAP cycle is inserted between consecutive repetitions, with d_valid=0 and d_out=0. There is no gap after the last repetition. Total cycles from edge k+1 to done = PAT_W*N + (N-1) + 1.
- Undefined: the GAP state does not exist; repetitions are back-to-back.

Decomposition:
- Package seq_pkg holds:
  - state encoding constants: IDLE=2'b00, SHIFT=2'b01, GAP=2'b10, DONE=2'b11;
  - default PATTERN constant PAT_101=3'b101.
  - The detector shares this package.
- One natural sub-module: seq_tx_counter, combining the bit-index down-counter and the repeat down-counter. It outputs last_bit and last_rep flags to the FSM.

Test Plan:
- reset=0 for 2 cycles, then 1; start=0 -> d_out=0, d_valid=0, busy=0, done=0, for 5 cycles.
- start=1 one cycle, repeat_cnt=1, default pattern -> d_out 1,0,1 with d_valid=1 on the next 3 edges; done=1 on the 4th edge; busy=0 on the 5th.
- repeat_cnt=2, no gap -> d_out=101101 over 6 cycles; the detector flags 2 matches; done after the 6th bit.
- SEQ_GEN_GAP_EN defined, repeat_cnt=2 -> d_out stream 1,0,1,(0 with d_valid=0),1,0,1; done at cycle 8.
- load_pat=1 with pattern_in=3'b110 and start=1 together -> 1,1,0 transmitted. A second load_pat=1 (pattern_in=3'b011) during busy is ignored, so the next start also sends 110.
- reset=0 asserted after the 2nd bit of a repeat_cnt=3 run -> next edge d_valid=0, busy=0, no done pulse, and the pattern register returns to 101.
- repeat_cnt=0 with start=1 -> no d_valid; done=1 exactly one cycle later.
